// File: rtl/firefly_burst_rx_pkg.sv
// Shared constants and FSM state type for the firefly relay receive path.
package firefly_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned RELAY_W = 15000;
  localparam int unsigned MIN_W   = 100;
  localparam int unsigned MAX_W   = 20000;
  localparam int unsigned GAP_MAX = 50000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/firefly_burst_rx_if.sv
// Flash input and burst result bundle; master drives the flash line, slave reports bursts.
interface firefly_burst_rx_if #(
  parameter int unsigned N_W = 8
);

  logic           f_in;
  logic           burst_valid;
  logic [N_W-1:0] burst_cnt;
  logic           burst_err;
  logic           busy;

  modport master (
    output f_in,
    input  burst_valid,
    input  burst_cnt,
    input  burst_err,
    input  busy
  );

  modport slave (
    input  f_in,
    output burst_valid,
    output burst_cnt,
    output burst_err,
    output busy
  );

endinterface

// File: rtl/firefly_burst_rx_sync.sv
// Two-flop synchroniser (s1 -> f_s) with edge strobes that change on the same edge as f_s.
module firefly_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic f_s,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic f_s_q, f_s_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = d_in;
    f_s_d  = s1_q;
    rise_d = s1_q & ~f_s_q;
    fall_d = ~s1_q & f_s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      f_s_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      f_s_q  <= f_s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign f_s  = f_s_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/firefly_burst_rx.sv
// Groups synchronised relay flashes into bursts, drops glitches, flags over-length
// pulses and reports one result per burst once the line stays dark for GAP_MAX cycles.
module firefly_burst_rx #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned MIN_W   = firefly_pkg::MIN_W,
  parameter int unsigned MAX_W   = firefly_pkg::MAX_W,
  parameter int unsigned GAP_MAX = firefly_pkg::GAP_MAX,
  parameter int unsigned N_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  firefly_burst_rx_if.slave bus
);

  import firefly_pkg::*;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] WSAT_C = CNT_W'(MAX_W + 1);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic f_s, f_rise, f_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [N_W-1:0]   ncnt_q, ncnt_d;
  logic             err_q, err_d;
  logic             close_q, close_d;
  logic [N_W-1:0]   res_cnt_q, res_cnt_d;
  logic             res_err_q, res_err_d;
  logic             valid_q, valid_d;
  logic [N_W-1:0]   cnt_q, cnt_d;
  logic             berr_q, berr_d;
  logic [N_W-1:0]   ncnt_upd;
  logic             err_upd;

  firefly_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (bus.f_in),
    .f_s  (f_s),
    .rise (f_rise),
    .fall (f_fall)
  );

  // rise/fall coincide with f_s toggling, so in IDLE/GAP a high f_s is always
  // a rise and in HIGH a low f_s is always a fall.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    gcnt_d    = gcnt_q;
    ncnt_d    = ncnt_q;
    err_d     = err_q;
    close_d   = 1'b0;
    res_cnt_d = res_cnt_q;
    res_err_d = res_err_q;
    ncnt_upd  = ncnt_q;
    err_upd   = err_q;
    valid_d   = close_q;
    cnt_d     = close_q ? res_cnt_q : cnt_q;
    berr_d    = close_q ? res_err_q : berr_q;

    unique case (state_q)
      IDLE: begin
        if (f_rise) begin
          state_d = HIGH;
          wcnt_d  = ONE_C;
        end
      end
      HIGH: begin
        if (f_fall) begin
          if (wcnt_q > MAX_C) begin
            err_upd = 1'b1;
          end else if (wcnt_q >= MIN_C && ncnt_q != '1) begin
            ncnt_upd = ncnt_q + 1'b1;
          end
          ncnt_d = ncnt_upd;
          err_d  = err_upd;
          if (ncnt_upd != '0 || err_upd) begin
            state_d = GAP;
            gcnt_d  = ONE_C;
          end else begin
            state_d = IDLE;
          end
        end else if (f_s && wcnt_q != WSAT_C) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (f_rise) begin
          state_d = HIGH;
          wcnt_d  = ONE_C;
        end else if (gcnt_q != GAP_C) begin
          gcnt_d = gcnt_q + 1'b1;
        end else begin
          close_d   = 1'b1;
          res_cnt_d = ncnt_q;
          res_err_d = err_q;
          ncnt_d    = '0;
          err_d     = 1'b0;
          gcnt_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      gcnt_q    <= '0;
      ncnt_q    <= '0;
      err_q     <= 1'b0;
      close_q   <= 1'b0;
      res_cnt_q <= '0;
      res_err_q <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      gcnt_q    <= gcnt_d;
      ncnt_q    <= ncnt_d;
      err_q     <= err_d;
      close_q   <= close_d;
      res_cnt_q <= res_cnt_d;
      res_err_q <= res_err_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      berr_q    <= berr_d;
    end
  end

  assign bus.burst_valid = valid_q;
  assign bus.burst_cnt   = cnt_q;
  assign bus.burst_err   = berr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_firefly_burst_rx.sv
// Scoreboard bench: a run-length model of the flash line predicts each burst result
// and its strobe cycle; a negedge monitor pops and compares whenever a strobe appears.
module tb_firefly_burst_rx;

  localparam int TB_CNT_W   = 10;
  localparam int TB_MIN_W   = 10;
  localparam int TB_MAX_W   = 200;
  localparam int TB_GAP_MAX = 400;
  localparam int TB_N_W     = 8;
  localparam int TB_NSAT    = 255;
  localparam int DARK       = TB_GAP_MAX + 10;

  typedef struct {
    int cnt;
    int err;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  firefly_burst_rx_if #(.N_W(TB_N_W)) bus ();

  firefly_burst_rx #(
    .CNT_W  (TB_CNT_W),
    .MIN_W  (TB_MIN_W),
    .MAX_W  (TB_MAX_W),
    .GAP_MAX(TB_GAP_MAX),
    .N_W    (TB_N_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   n_strobes = 0;
  int   last_cnt  = -1;
  int   last_err  = -1;
  exp_t exp_q[$];

  int m_in_high = 0;
  int m_hi      = 0;
  int m_lo      = 0;
  int m_n       = 0;
  int m_err     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: measure high/low run lengths of the sampled line. A burst closes
  // after GAP_MAX+1 consecutive low samples; its strobe is due 3 edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_in_high = 0; m_hi = 0; m_lo = 0; m_n = 0; m_err = 0;
      exp_q.delete();
    end else if (bus.f_in) begin
      if (m_in_high == 0) begin
        m_in_high = 1;
        m_hi      = 1;
      end else begin
        m_hi++;
      end
    end else begin
      if (m_in_high != 0) begin
        m_in_high = 0;
        m_lo      = 1;
        if (m_hi > TB_MAX_W) m_err = 1;
        else if (m_hi >= TB_MIN_W && m_n < TB_NSAT) m_n++;
      end else begin
        m_lo++;
      end
      if ((m_n > 0 || m_err != 0) && m_lo == TB_GAP_MAX + 1) begin
        exp_q.push_back('{cnt: m_n, err: m_err, due: cyc + 3});
        m_n   = 0;
        m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.burst_valid === 1'b1) begin
      exp_t e;
      n_strobes++;
      last_cnt = int'(bus.burst_cnt);
      last_err = int'(bus.burst_err);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got strobe cnt=%0d err=%0d at cycle %0d, expected none",
                 last_cnt, last_err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("burst_cnt", last_cnt, e.cnt);
        check("burst_err", last_err, e.err);
        check("strobe_cycle", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic level, input int n);
    bus.f_in = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_gap(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic end_burst(input string name, input int exp_strobes, input int base);
    drive(1'b0, DARK);
    check({name, "_strobes"}, n_strobes - base, exp_strobes);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int base;
    bus.f_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(bus.burst_valid), 0);
    check("rst_cnt", int'(bus.burst_cnt), 0);
    check("rst_err", int'(bus.burst_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    drive(1'b0, 5);

    // three relay-width pulses
    base = n_strobes;
    drive(1'b1, 20);
    check("busy_in_pulse", int'(bus.busy), 1);
    drive(1'b1, 130);
    drive(1'b0, 200);
    pulse_gap(150, 200);
    drive(1'b1, 150);
    end_burst("three", 1, base);
    check("three_cnt", last_cnt, 3);
    check("three_err", last_err, 0);

    // glitches only
    base = n_strobes;
    pulse_gap(5, 20);
    drive(1'b1, 5);
    end_burst("glitch", 0, base);

    // one over-length pulse among two valid ones
    base = n_strobes;
    pulse_gap(150, 200);
    pulse_gap(250, 200);
    drive(1'b1, 150);
    end_burst("over", 1, base);
    check("over_cnt", last_cnt, 2);
    check("over_err", last_err, 1);

    // width boundaries MIN_W-1, MIN_W, MAX_W, MAX_W+1
    base = n_strobes;
    pulse_gap(TB_MIN_W - 1, 50);
    pulse_gap(TB_MIN_W, 50);
    pulse_gap(TB_MAX_W, 50);
    drive(1'b1, TB_MAX_W + 1);
    end_burst("edges", 1, base);
    check("edges_cnt", last_cnt, 2);
    check("edges_err", last_err, 1);

    // rise on the timeout cycle keeps the burst open
    base = n_strobes;
    pulse_gap(150, TB_GAP_MAX);
    drive(1'b1, 150);
    end_burst("race", 1, base);
    check("race_cnt", last_cnt, 2);

    // one more dark cycle closes the first burst
    base = n_strobes;
    pulse_gap(150, TB_GAP_MAX + 1);
    drive(1'b1, 150);
    end_burst("split", 2, base);
    check("split_cnt", last_cnt, 1);

    // count saturation
    base = n_strobes;
    for (int i = 0; i < 300; i++) pulse_gap(20, 30);
    end_burst("sat", 1, base);
    check("sat_cnt", last_cnt, TB_NSAT);
    check("sat_err", last_err, 0);

    // reset mid-burst; line already high when reset releases
    base = n_strobes;
    pulse_gap(150, 200);
    pulse_gap(150, 100);
    rst = 1'b1;
    drive(1'b0, 2);
    check("midrst_valid", int'(bus.burst_valid), 0);
    check("midrst_cnt", int'(bus.burst_cnt), 0);
    check("midrst_err", int'(bus.burst_err), 0);
    check("midrst_busy", int'(bus.busy), 0);
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 150);
    end_burst("midrst", 1, base);
    check("midrst_last_cnt", last_cnt, 1);

    // randomised bursts against the model
    for (int b = 0; b < 8; b++) begin
      int np;
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        int w;
        int g;
        w = int'($urandom_range(1, 260));
        g = ($urandom_range(0, 3) == 0) ? TB_GAP_MAX + int'($urandom_range(0, 1))
                                        : int'($urandom_range(1, TB_GAP_MAX));
        drive(1'b1, w);
        if (p != np - 1) drive(1'b0, g);
      end
      drive(1'b0, DARK);
      check("rand_pending", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
